// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    VEND,
    CHANGE
  } state_t;

  localparam logic [1:0] HALF_VAL = 2'd1;
  localparam logic [1:0] ONE_VAL  = 2'd2;

  function automatic logic [1:0] coin_value(
    input logic half_i,
    input logic one_i
  );
    return (half_i ? HALF_VAL : 2'd0)
         + (one_i  ? ONE_VAL  : 2'd0);
  endfunction

endpackage

// File: rtl/vend_change_out.sv
// Change/refund down-counter: emits one half_out pulse per
// half-dollar owed, on consecutive cycles after a load.
module vend_change_out #(
  parameter int CREDIT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] load_val_i,
  output logic                half_out_o
);

  typedef logic [CREDIT_W-1:0] cnt_t;

  localparam cnt_t ONE_C = cnt_t'(1);

  cnt_t cnt_q;
  cnt_t cnt_d;
  logic half_q;
  logic half_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE_C;
    end
    // pulse is high for every cycle a coin is still owed
    half_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

  assign half_out_o = half_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, selection, vend and change.
// Optional refund-on-cancel is enabled with `define VEND_CANCEL_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter  int PRICE      = 5,
  parameter  int N_PROD     = 4,
  parameter  int MAX_CREDIT = 15,
  localparam int CREDIT_W   = $clog2(MAX_CREDIT + 1),
  localparam int ID_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                half_dollar,
  input  logic                one_dollar,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  output logic                sel_ready,
  output logic                dispense,
  output logic [ID_W-1:0]     dispense_id,
  output logic                collect,
  output logic                half_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [CREDIT_W:0]   sum_t;

  localparam credit_t PRICE_C = credit_t'(PRICE);
  localparam credit_t ONE_C   = credit_t'(1);
  localparam sum_t    MAX_S   = sum_t'(MAX_CREDIT);

  state_t          state_q;
  state_t          state_d;
  credit_t         credit_q;
  credit_t         credit_d;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] id_d;
  logic            ready_q;
  logic            ready_d;
  logic            disp_q;
  logic            disp_d;
  logic            coll_q;
  logic            coll_d;
  logic            rej_q;
  logic            rej_d;
  logic            busy_q;
  logic            busy_d;

  logic [1:0] coin_v;
  logic       coin_ev;
  sum_t       sum;
  logic       coin_ok;
  logic       sel_hit;
  logic       cancel_hit;
  logic       load;
  credit_t    load_val;

  assign coin_v  = coin_value(half_dollar, one_dollar);
  assign coin_ev = half_dollar | one_dollar;
  assign sum     = sum_t'(credit_q) + sum_t'(coin_v);
  assign coin_ok = coin_ev && (sum <= MAX_S);
  assign sel_hit = sel_valid && ready_q;

`ifdef VEND_CANCEL_EN
  assign cancel_hit = (state_q == ACCUM) && cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    id_d     = id_q;
    disp_d   = 1'b0;
    coll_d   = 1'b0;
    rej_d    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      IDLE, ACCUM: begin
        rej_d = coin_ev && !coin_ok;
        if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
        end
        // cancel wins over a same-edge selection
        if (cancel_hit) begin
          state_d  = CHANGE;
          load     = 1'b1;
          load_val = credit_d;
        end else if (sel_hit) begin
          state_d = VEND;
          id_d    = sel_id;
          disp_d  = 1'b1;
          coll_d  = 1'b1;
        end else begin
          state_d = (credit_d != '0) ? ACCUM : IDLE;
        end
      end
      VEND: begin
        rej_d    = coin_ev;
        credit_d = credit_q - PRICE_C;
        if (credit_d != '0) begin
          state_d  = CHANGE;
          load     = 1'b1;
          load_val = credit_d;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        rej_d    = coin_ev;
        credit_d = credit_q - ONE_C;
        state_d  = (credit_d == '0) ? IDLE : CHANGE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    ready_d = (state_d == ACCUM) && (credit_d >= PRICE_C);
    busy_d  = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      id_q     <= '0;
      ready_q  <= 1'b0;
      disp_q   <= 1'b0;
      coll_q   <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      id_q     <= id_d;
      ready_q  <= ready_d;
      disp_q   <= disp_d;
      coll_q   <= coll_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  vend_change_out #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .half_out_o (half_out)
  );

  assign credit      = credit_q;
  assign sel_ready   = ready_q;
  assign dispense    = disp_q;
  assign dispense_id = id_q;
  assign collect     = coll_q;
  assign coin_reject = rej_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table, corner
// sequences and random traffic against a credit-ledger model.
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int MAXC  = 15;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       half_dollar;
  logic       one_dollar;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       sel_ready;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       collect;
  logic       half_out;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;

  vend_ctrl #(
    .PRICE      (PRICE),
    .N_PROD     (4),
    .MAX_CREDIT (MAXC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .half_dollar (half_dollar),
    .one_dollar  (one_dollar),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cancel      (cancel),
    .sel_ready   (sel_ready),
    .dispense    (dispense),
    .dispense_id (dispense_id),
    .collect     (collect),
    .half_out    (half_out),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cr;
    logic       rdy;
    logic       dsp;
    logic       col;
    logic       hf;
    logic       rej;
    logic       bsy;
    logic [1:0] id;
  } outs_t;

  typedef struct {
    bit         rs;
    bit         h;
    bit         o;
    bit         sv;
    logic [1:0] sid;
    bit         cn;
    outs_t      e;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  vec_t  tbl[$];

  int         m_cr;
  bit         m_vend;
  bit         m_pay;
  bit         m_rej;
  logic [1:0] m_id;

  function automatic outs_t mk_o(int cr, bit rdy, bit dsp, bit col,
                                 bit hf, bit rej, bit bsy, int id);
    outs_t r;
    r.cr  = 4'(cr);
    r.rdy = rdy;
    r.dsp = dsp;
    r.col = col;
    r.hf  = hf;
    r.rej = rej;
    r.bsy = bsy;
    r.id  = 2'(id);
    return r;
  endfunction

  function automatic vec_t mk(bit rs, bit h, bit o, bit sv,
                              int sid, bit cn, outs_t e);
    vec_t v;
    v.rs  = rs;
    v.h   = h;
    v.o   = o;
    v.sv  = sv;
    v.sid = 2'(sid);
    v.cn  = cn;
    v.e   = e;
    return v;
  endfunction

  task automatic check(input string nm, input outs_t e);
    outs_t a;
    a.cr  = credit;
    a.rdy = sel_ready;
    a.dsp = dispense;
    a.col = collect;
    a.hf  = half_out;
    a.rej = coin_reject;
    a.bsy = busy;
    a.id  = dispense_id;
    if (!e.dsp) a.id = e.id;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %p want %p", nm, a, e);
    end
  endtask

  task automatic step(input bit rs, input bit h, input bit o,
                      input bit sv, input logic [1:0] sid,
                      input bit cn);
    @(negedge clk);
    reset       = rs;
    half_dollar = h;
    one_dollar  = o;
    sel_valid   = sv;
    sel_id      = sid;
    cancel      = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // credit ledger: coins add, a vend takes PRICE, change pays 1/cycle
  task automatic model_step(input bit h, input bit o, input bit sv,
                            input logic [1:0] sid, input bit cn);
    int coin;
    bit ready;
    bit had;
    coin  = (h ? 1 : 0) + (o ? 2 : 0);
    ready = !m_vend && !m_pay && (m_cr >= PRICE);
    m_rej = 1'b0;
    if (m_vend) begin
      m_vend = 1'b0;
      m_cr   = m_cr - PRICE;
      m_pay  = (m_cr > 0);
      m_rej  = (coin > 0);
    end else if (m_pay) begin
      m_cr  = m_cr - 1;
      m_pay = (m_cr > 0);
      m_rej = (coin > 0);
    end else begin
      had = (m_cr > 0);
      if (coin > 0) begin
        if (m_cr + coin > MAXC) m_rej = 1'b1;
        else m_cr = m_cr + coin;
      end
      if (CANCEL_EN && cn && had) m_pay = 1'b1;
      else if (sv && ready) begin
        m_vend = 1'b1;
        m_id   = sid;
      end
    end
  endtask

  function automatic outs_t model_out();
    return mk_o(m_cr, !m_vend && !m_pay && (m_cr >= PRICE),
                m_vend, m_vend, m_pay, m_rej, m_vend | m_pay,
                int'(m_id));
  endfunction

  initial begin
    int n_half;
    int n_disp;
    outs_t z;
    z = mk_o(0, 0, 0, 0, 0, 0, 0, 0);
    reset       = 1'b1;
    half_dollar = 1'b0;
    one_dollar  = 1'b0;
    sel_valid   = 1'b0;
    sel_id      = 2'd0;
    cancel      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", z);

    // one,one,half then select id 2: exact price, no change
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(2,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(4,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0,0, mk_o(5,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,2,0, mk_o(5,0,1,1,0,0,1,2)));
    tbl.push_back(mk(0,0,0,0,0,0, z));
    tbl.push_back(mk(0,0,0,0,0,0, z));
    // three dollars then select: one half back
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(2,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(4,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(6,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,1,0, mk_o(6,0,1,1,0,0,1,1)));
    tbl.push_back(mk(0,0,0,0,0,0, mk_o(1,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0,0, z));
    // overflow: 14 + one is rejected
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(0,0,1,0,0,0,
        mk_o(2*k, 2*k >= PRICE, 0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(14,1,0,0,0,1,0,0)));
    tbl.push_back(mk(0,0,0,0,0,0, mk_o(14,1,0,0,0,0,0,0)));
    tbl.push_back(mk(1,0,0,0,0,0, z));
    // both coins on one edge at 12 reaches the cap
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(0,0,1,0,0,0,
        mk_o(2*k, 2*k >= PRICE, 0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,1,0,0,0, mk_o(15,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0,0, mk_o(15,1,0,0,0,1,0,0)));
    // select below price ignored; coins in VEND/CHANGE rejected
    tbl.push_back(mk(1,0,0,0,0,0, z));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(2,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(4,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,3,0, mk_o(4,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(6,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(8,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,3,0, mk_o(8,0,1,1,0,0,1,3)));
    tbl.push_back(mk(0,1,0,0,0,0, mk_o(3,0,0,0,1,1,1,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(2,0,0,0,1,1,1,0)));
    tbl.push_back(mk(0,0,0,0,0,0, mk_o(1,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0,0, z));
    // coin on the accepting edge is credited and returned
    tbl.push_back(mk(1,0,0,0,0,0, z));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(2,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,0,1,0,0,0, mk_o(4,0,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,0,0,0, mk_o(5,1,0,0,0,0,0,0)));
    tbl.push_back(mk(0,1,0,1,0,0, mk_o(6,0,1,1,0,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0,0, mk_o(1,0,0,0,1,0,1,0)));
    tbl.push_back(mk(0,0,0,0,0,0, z));

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].h, tbl[i].o, tbl[i].sv,
           tbl[i].sid, tbl[i].cn);
      check($sformatf("vec%0d", i), tbl[i].e);
    end

    // cancel and select on the same edge at credit 3
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    n_half = int'(half_out);
    n_disp = int'(dispense);
    check("cancel_edge", mk_o(3, 0, 0, 0, CANCEL_EN, 0, CANCEL_EN, 0));
    repeat (5) begin
      idle_step();
      n_half += int'(half_out);
      n_disp += int'(dispense);
    end
    total++;
    if (n_half != (CANCEL_EN ? 3 : 0) || n_disp != 0) begin
      bad++;
      $display("FAIL cancel_count: got half=%0d disp=%0d want half=%0d disp=0",
               n_half, n_disp, CANCEL_EN ? 3 : 0);
    end
    check("cancel_end",
          mk_o(CANCEL_EN ? 0 : 3, 0, 0, 0, 0, 0, 0, 0));

    // asynchronous reset in the middle of change
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    idle_step();
    check("pre_rst", mk_o(3, 0, 0, 0, 1, 0, 1, 0));
    @(negedge clk);
    sel_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("async_rst", z);
    n_half = 0;
    repeat (5) begin
      idle_step();
      n_half += int'(half_out) + int'(dispense);
    end
    total++;
    if (n_half != 0) begin
      bad++;
      $display("FAIL post_rst_pulses: got %0d want 0", n_half);
    end
    check("post_rst", z);

    // random traffic against the ledger model
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    m_cr   = 0;
    m_vend = 1'b0;
    m_pay  = 1'b0;
    m_rej  = 1'b0;
    m_id   = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      bit         h;
      bit         o;
      bit         sv;
      bit         cn;
      logic [1:0] sid;
      h   = ($urandom_range(5) == 0);
      o   = ($urandom_range(5) == 0);
      sv  = ($urandom_range(3) == 0);
      cn  = ($urandom_range(19) == 0);
      sid = 2'($urandom_range(3));
      step(1'b0, h, o, sv, sid, cn);
      model_step(h, o, sv, sid, cn);
      check($sformatf("rand%0d", i), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 5, the product price in half-dollar units (5 = 2.50).
REQ-002 SHALL have parameter N_PROD, default 4, the number of selectable products (min 1).
REQ-003 SHALL have parameter MAX_CREDIT, default 15, the highest credit in half-dollar units; must be >= PRICE.
REQ-004 SHALL have localparams CREDIT_W = $clog2(MAX_CREDIT+1) and ID_W = max(1,$clog2(N_PROD)).
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port half_dollar  in  1  single-cycle pulse for a 0.50 coin inserted.
REQ-008 SHALL have port one_dollar  in  1  single-cycle pulse for a 1.00 coin inserted.
REQ-009 SHALL have port sel_valid  in  1  product selection request.
REQ-010 SHALL have port sel_id  in  ID_W  requested product index.
REQ-011 SHALL have port cancel  in  1  refund request.
REQ-012 SHALL have port sel_ready  out  1  selection can be accepted.
REQ-013 SHALL have port dispense  out  1  one-cycle vend pulse.
REQ-014 SHALL have port dispense_id  out  ID_W  product vended; valid while dispense is high.
REQ-015 SHALL have port collect  out  1  one-cycle pulse moving PRICE into the cash box, coincident with dispense.
REQ-016 SHALL have port half_out  out  1  one-cycle pulse per 0.50 coin of change or refund.
REQ-017 SHALL have port coin_reject  out  1  one-cycle pulse: coin event not credited.
REQ-018 SHALL have port credit  out  CREDIT_W  current credit in half-dollar units.
REQ-019 SHALL have port busy  out  1  high in VEND or CHANGE.

Function
REQ-020 SHALL implement states IDLE, ACCUM, VEND, CHANGE; IDLE <=> credit == 0 with no vend pending.
REQ-021 In IDLE/ACCUM a coin event SHALL add 1 (half), 2 (one) or 3 (both same cycle) to credit at that edge; IDLE->ACCUM when the result is nonzero.
REQ-022 If credit + event value > MAX_CREDIT, the whole event SHALL be dropped and coin_reject pulsed the next cycle.
REQ-023 Coin events in VEND or CHANGE SHALL be dropped with coin_reject pulsed.
REQ-024 sel_ready SHALL be registered-credit based: high iff state == ACCUM and credit >= PRICE.
REQ-025 A selection SHALL be accepted on an edge with sel_valid && sel_ready; sel_id captured; next state VEND. Otherwise sel_valid is ignored, with no side effect.
REQ-026 A coin accepted on the same edge as a selection SHALL be credited and included in change.
REQ-027 VEND SHALL last one cycle: dispense=1, collect=1, dispense_id=captured id; credit -= PRICE; then CHANGE if credit > 0, else IDLE.
REQ-028 CHANGE SHALL pulse half_out on consecutive cycles, decrementing credit by 1 each, and go to IDLE in the cycle after credit reaches 0.
REQ-029 Latency SHALL be: accepting edge -> dispense next cycle -> first half_out the cycle after.
REQ-030 All outputs SHALL be registered; dispense, collect, half_out and coin_reject never high longer than one cycle per event.

Reset
REQ-031 On reset assertion the block SHALL go to IDLE immediately: credit=0, sel_ready=0, dispense=0, dispense_id=0, collect=0, half_out=0, coin_reject=0, busy=0.
REQ-032 Reset during VEND or CHANGE SHALL abandon pending vend and change without further pulses.

Configuration
REQ-033 With macro VEND_CANCEL_EN defined, cancel in ACCUM SHALL move to CHANGE and refund all credit; cancel beats a selection on the same edge, and a same-edge coin is refunded too.
REQ-034 Without VEND_CANCEL_EN, the cancel port SHALL exist but be ignored.

Structure
REQ-035 Package vend_pkg SHALL hold the state enum and the coin value constants HALF_VAL=1 and ONE_VAL=2.
REQ-036 Sub-module vend_change_out SHALL own the CHANGE down-counter and half_out pulse generation.

Verification
REQ-037 Bench SHALL cover: one,one,half, then sel_valid with sel_id=2 -> dispense with dispense_id=2 and collect one cycle later, no half_out, back to IDLE.
REQ-038 Bench SHALL cover: three one_dollar pulses (credit 6), then select -> dispense, then exactly one half_out, credit 0.
REQ-039 Bench SHALL cover: credit 14 plus one_dollar -> coin_reject, credit stays 14; with both coins on one edge at credit 12 -> credit 15.
REQ-040 Bench SHALL cover: sel_valid at credit 4 -> ignored; coin during CHANGE -> coin_reject and change count unchanged.
REQ-041 Bench SHALL cover, with VEND_CANCEL_EN: credit 3 then cancel + sel_valid same edge -> no dispense, three half_out pulses. Without the macro: cancel has no effect.
REQ-042 Bench SHALL cover: reset asserted mid-CHANGE -> all outputs 0 asynchronously and no further half_out.
